// File: rtl/mnk_pkg.sv
// Shared codes and state encoding for the m,n,k game engine.
package mnk_pkg;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  localparam logic [1:0] RES_NONE     = 2'b00;
  localparam logic [1:0] RES_PLAYER   = 2'b01;
  localparam logic [1:0] RES_COMPUTER = 2'b10;
  localparam logic [1:0] RES_DRAW     = 2'b11;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [1:0] side_code(input logic side);
    return side ? CELL_COMPUTER : CELL_PLAYER;
  endfunction

endpackage

// File: rtl/mnk_line_scan.sv
// Combinational K-in-a-row detector over every horizontal, vertical,
// diagonal and anti-diagonal window of an N x N board.
module mnk_line_scan
  import mnk_pkg::*;
#(
  parameter  int BOARD_N = 3,
  parameter  int WIN_K   = 3,
  localparam int CELLS   = BOARD_N * BOARD_N
) (
  input  logic [2*CELLS-1:0] board_i,
  output logic               win_o,
  output logic [1:0]         winner_o
);

  // One slot per (direction, start cell); slots whose window leaves the board stay 0.
  logic [4*CELLS-1:0] p_hit;
  logic [4*CELLS-1:0] c_hit;

  for (genvar d = 0; d < 4; d++) begin : g_dir
    localparam int DR = (d == 0) ? 0 : 1;
    localparam int DC = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
    for (genvar r = 0; r < BOARD_N; r++) begin : g_row
      for (genvar c = 0; c < BOARD_N; c++) begin : g_col
        localparam int SLOT  = d * CELLS + r * BOARD_N + c;
        localparam int START = r * BOARD_N + c;
        localparam int ER    = r + (WIN_K - 1) * DR;
        localparam int EC    = c + (WIN_K - 1) * DC;
        if (ER < BOARD_N && EC >= 0 && EC < BOARD_N) begin : g_win
          logic [WIN_K-1:0] eq;
          logic             all_same;
          for (genvar k = 0; k < WIN_K; k++) begin : g_cell
            localparam int IDX = (r + k * DR) * BOARD_N + (c + k * DC);
            if (k == 0) begin : g_first
              assign eq[k] = board_i[2*IDX +: 2] != CELL_EMPTY;
            end else begin : g_rest
              assign eq[k] = board_i[2*IDX +: 2] == board_i[2*START +: 2];
            end
          end
          assign all_same    = &eq;
          assign p_hit[SLOT] = all_same && (board_i[2*START +: 2] == CELL_PLAYER);
          assign c_hit[SLOT] = all_same && (board_i[2*START +: 2] == CELL_COMPUTER);
        end else begin : g_nowin
          assign p_hit[SLOT] = 1'b0;
          assign c_hit[SLOT] = 1'b0;
        end
      end
    end
  end

  assign win_o    = (|p_hit) | (|c_hit);
  assign winner_o = (|c_hit) ? CELL_COMPUTER : (|p_hit) ? CELL_PLAYER : CELL_EMPTY;

endmodule

// File: rtl/mnk_game_engine.sv
// N x N, K-in-a-row two-sided game engine: move handshake, legality checks,
// one-cycle win/draw evaluation and a frozen final board until new_game.
module mnk_game_engine
  import mnk_pkg::*;
#(
  parameter  int BOARD_N = 3,
  parameter  int WIN_K   = 3,
  localparam int CELLS   = BOARD_N * BOARD_N,
  localparam int POS_W   = $clog2(CELLS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic               move_side,
  input  logic [POS_W-1:0]   move_pos,
  output logic               move_ready,
  output logic               illegal,
  output logic [2*CELLS-1:0] board,
  output logic               turn,
  output logic [1:0]         result,
  output logic               game_over,
  output logic [POS_W:0]     move_count
);

  state_e             state_q, state_d;
  logic [2*CELLS-1:0] board_q, board_d;
  logic               turn_q, turn_d;
  logic [1:0]         result_q, result_d;
  logic [POS_W:0]     count_q, count_d;
  logic               illegal_q, illegal_d;

  logic [CELLS-1:0]   hit;
  logic [CELLS-1:0]   occ;
  logic               pos_ok;
  logic               accept;
  logic               legal;
  logic               wr_en;
  logic               board_full;
  logic               scan_win;
  logic [1:0]         scan_winner;

  assign accept     = move_valid && (state_q == S_READY);
  assign pos_ok     = {1'b0, move_pos} < (POS_W+1)'(CELLS);
  assign legal      = pos_ok && !(|(hit & occ)) && (move_side == turn_q);
  assign wr_en      = accept && legal;
  assign board_full = count_q == (POS_W+1)'(CELLS);

  // new_game wins over a same-cycle write, so a move offered with it is dropped.
  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    assign hit[i] = move_pos == POS_W'(i);
    assign occ[i] = board_q[2*i +: 2] != CELL_EMPTY;
    assign board_d[2*i +: 2] = new_game          ? CELL_EMPTY :
                               (wr_en && hit[i]) ? side_code(move_side) :
                                                   board_q[2*i +: 2];
  end

  mnk_line_scan #(
    .BOARD_N (BOARD_N),
    .WIN_K   (WIN_K)
  ) u_scan (
    .board_i  (board_q),
    .win_o    (scan_win),
    .winner_o (scan_winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_READY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = S_READY;
    end else begin
      unique case (state_q)
        S_READY: if (wr_en) state_d = S_CHECK;
        S_CHECK: state_d = (scan_win || board_full) ? S_DONE : S_READY;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_READY;
      endcase
    end
  end

  // Only the side that just moved can complete a line, so a win on the last cell beats the draw.
  always_comb begin
    turn_d    = turn_q;
    result_d  = result_q;
    count_d   = count_q;
    illegal_d = 1'b0;
    if (new_game) begin
      turn_d   = 1'b0;
      result_d = RES_NONE;
      count_d  = '0;
    end else begin
      unique case (state_q)
        S_READY: begin
          if (accept) begin
            if (legal) count_d = count_q + (POS_W+1)'(1);
            else       illegal_d = 1'b1;
          end
        end
        S_CHECK: begin
          if (scan_win)        result_d = scan_winner;
          else if (board_full) result_d = RES_DRAW;
          else                 turn_d   = ~turn_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      board_q   <= '0;
      turn_q    <= 1'b0;
      result_q  <= RES_NONE;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      board_q   <= board_d;
      turn_q    <= turn_d;
      result_q  <= result_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    move_ready = state_q == S_READY;
    game_over  = state_q == S_DONE;
    illegal    = illegal_q;
    board      = board_q;
    turn       = turn_q;
    result     = result_q;
    move_count = count_q;
  end

endmodule
